// File: rtl/blackparrot_fpga_host_pkg.sv
// NBF packet format and AXI/FIFO widths shared by the FPGA host I/O blocks.
package blackparrot_fpga_host_pkg;

    localparam int unsigned S_AXI_ADDR_WIDTH   = 64;
    localparam int unsigned S_AXI_DATA_WIDTH   = 64;
    localparam int unsigned S_AXI_ID_WIDTH     = 4;
    localparam int unsigned fifo_data_width_p  = 32;
    localparam int unsigned nbf_opcode_width_p = 8;
    localparam int unsigned nbf_addr_width_p   = 64;
    localparam int unsigned nbf_data_width_p   = 64;

    localparam int unsigned nbf_width_lp =
        nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
    localparam int unsigned nbf_flits_lp =
        (nbf_width_lp + fifo_data_width_p - 1) / fifo_data_width_p;
    localparam int unsigned nbf_padded_width_lp = nbf_flits_lp * fifo_data_width_p;

    localparam logic [nbf_opcode_width_p-1:0] nbf_op_write_1b = 8'h00;
    localparam logic [nbf_opcode_width_p-1:0] nbf_op_write_2b = 8'h01;
    localparam logic [nbf_opcode_width_p-1:0] nbf_op_write_4b = 8'h02;
    localparam logic [nbf_opcode_width_p-1:0] nbf_op_write_8b = 8'h03;
    localparam logic [nbf_opcode_width_p-1:0] nbf_op_read_8b  = 8'h13;
    localparam logic [nbf_opcode_width_p-1:0] nbf_op_fence    = 8'hFE;
    localparam logic [nbf_opcode_width_p-1:0] nbf_op_finish   = 8'hFF;

    localparam logic [1:0] axi_resp_okay   = 2'b00;
    localparam logic [1:0] axi_resp_slverr = 2'b10;

    typedef struct packed {
        logic [nbf_opcode_width_p-1:0] opcode;
        logic [nbf_addr_width_p-1:0]   addr;
        logic [nbf_data_width_p-1:0]   data;
    } bp_nbf_s;

    typedef enum logic [1:0] {e_idle, e_drain, e_send, e_bresp} wr_state_e;
    typedef enum logic {e_ridle, e_rresp} rd_state_e;

    // Byte-lane mask keeping only the bytes covered by an AXI size of 1/2/4/8 B
    function automatic logic [nbf_data_width_p-1:0] nbf_size_mask(input logic [1:0] size);
        unique case (size)
            2'd0:    nbf_size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    nbf_size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    nbf_size_mask = 64'h0000_0000_FFFF_FFFF;
            default: nbf_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/blackparrot_fpga_host_io_out_if.sv
// AXI4 bus bundle between BlackParrot (master) and the host I/O-out subordinate.
interface blackparrot_fpga_host_io_out_if;
    import blackparrot_fpga_host_pkg::*;

    logic [S_AXI_ID_WIDTH-1:0]   awid;
    logic [S_AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awlock;
    logic [3:0]                  awcache;
    logic [2:0]                  awprot;
    logic [3:0]                  awqos;
    logic [3:0]                  awregion;
    logic                        awvalid;
    logic                        awready;

    logic [S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;

    logic [S_AXI_ID_WIDTH-1:0] bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [S_AXI_ID_WIDTH-1:0]   arid;
    logic [S_AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic [3:0]                  arqos;
    logic [3:0]                  arregion;
    logic                        arvalid;
    logic                        arready;

    logic [S_AXI_ID_WIDTH-1:0]   rid;
    logic [S_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/bsg_parallel_in_serial_out.sv
// Loads a wide word when empty and emits it as els_p flits, lowest flit first.
module bsg_parallel_in_serial_out #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  logic [width_p*els_p-1:0]   data_i,
    output logic                       ready_and_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    output logic                       last_o,
    input  logic                       yumi_i
);
    localparam int unsigned cnt_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p*els_p-1:0] shift_r;
    logic [cnt_w_lp-1:0]      cnt_r;
    logic                     valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            cnt_r   <= '0;
            valid_r <= 1'b0;
        end else if (valid_i && !valid_r) begin
            shift_r <= data_i;
            cnt_r   <= '0;
            valid_r <= 1'b1;
        end else if (yumi_i && valid_r) begin
            shift_r <= shift_r >> width_p;
            cnt_r   <= cnt_r + cnt_w_lp'(1);
            if (last_o) valid_r <= 1'b0;
        end
    end

    assign ready_and_o = ~valid_r;
    assign valid_o     = valid_r;
    assign data_o      = shift_r[width_p-1:0];
    assign last_o      = (cnt_r == cnt_w_lp'(els_p - 1));

endmodule

// File: rtl/blackparrot_fpga_host_io_out.sv
// AXI4 subordinate turning BP single-beat writes into NBF flits for the host; reads get SLVERR.
module blackparrot_fpga_host_io_out
    import blackparrot_fpga_host_pkg::*;
(
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    blackparrot_fpga_host_io_out_if.slave s_axi,
    output logic                          io_v_o,
    output logic [fifo_data_width_p-1:0]  io_data_o,
    input  logic                          io_ready_and_i
);
    wr_state_e state_r, state_n;
    rd_state_e rstate_r, rstate_n;

    logic                        rst_done_r;
    logic                        aw_got_r, w_got_r, err_r, wlast_r;
    logic [S_AXI_ADDR_WIDTH-1:0] addr_r;
    logic [S_AXI_ID_WIDTH-1:0]   id_r, rid_r;
    logic [7:0]                  len_r, rlen_r, rcnt_r;
    logic [2:0]                  size_r;
    logic [S_AXI_DATA_WIDTH-1:0] wdata_r;

    logic aw_hs, w_hs, ar_hs, r_hs, aw_have, w_have;
    logic piso_ready, piso_last, piso_load;
    logic [S_AXI_ADDR_WIDTH-1:0]  addr_c;
    logic [S_AXI_DATA_WIDTH-1:0]  wdata_c;
    logic [7:0]                   len_c;
    logic [2:0]                   size_c;
    logic                         wlast_c;
    bp_nbf_s                      pkt_c;
    logic [nbf_padded_width_lp-1:0] pkt_padded_c;

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid & s_axi.wready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;
    assign r_hs  = s_axi.rvalid & s_axi.rready;

    // Bypass the capture registers so a same-cycle handshake can start the packet immediately
    assign aw_have = aw_got_r | aw_hs;
    assign w_have  = w_got_r | w_hs;
    assign addr_c  = aw_got_r ? addr_r  : s_axi.awaddr;
    assign len_c   = aw_got_r ? len_r   : s_axi.awlen;
    assign size_c  = aw_got_r ? size_r  : s_axi.awsize;
    assign wdata_c = w_got_r  ? wdata_r : s_axi.wdata;
    assign wlast_c = w_got_r  ? wlast_r : s_axi.wlast;

    always_comb begin
        pkt_c        = '0;
        pkt_c.opcode = {6'b0, size_c[1:0]};
        pkt_c.addr   = addr_c;
        pkt_c.data   = (wdata_c >> {addr_c[2:0], 3'b000}) & nbf_size_mask(size_c[1:0]);
        pkt_padded_c = nbf_padded_width_lp'(pkt_c);
    end

    // Write FSM: state register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state_r <= e_idle;
        else                state_r <= state_n;
    end

    // Write FSM: next state
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle: if (aw_have && w_have) begin
                if ((len_c != 8'd0) || !wlast_c) state_n = wlast_c ? e_bresp : e_drain;
                else if (size_c > 3'd3)          state_n = e_bresp;
                else if (piso_ready)             state_n = e_send;
            end
            e_drain: if (w_hs && s_axi.wlast)                    state_n = e_bresp;
            e_send:  if (io_v_o && io_ready_and_i && piso_last)  state_n = e_bresp;
            e_bresp: if (s_axi.bready)                           state_n = e_idle;
            default:                                             state_n = e_idle;
        endcase
    end

    // Write FSM: outputs
    always_comb begin
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bid     = '0;
        s_axi.bresp   = axi_resp_okay;
        piso_load     = 1'b0;
        unique case (state_r)
            e_idle: begin
                s_axi.awready = rst_done_r & ~aw_got_r;
                s_axi.wready  = rst_done_r & ~w_got_r;
                piso_load     = (state_n == e_send);
            end
            e_drain: s_axi.wready = 1'b1;
            e_bresp: begin
                s_axi.bvalid = 1'b1;
                s_axi.bid    = id_r;
                s_axi.bresp  = err_r ? axi_resp_slverr : axi_resp_okay;
            end
            default: ;
        endcase
    end

    // AW/W capture while idle; error flag latched when leaving idle
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rst_done_r <= 1'b0;
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            err_r      <= 1'b0;
            wlast_r    <= 1'b0;
            addr_r     <= '0;
            id_r       <= '0;
            len_r      <= '0;
            size_r     <= '0;
            wdata_r    <= '0;
        end else begin
            rst_done_r <= 1'b1;
            if (state_r == e_idle) begin
                if (aw_hs) begin
                    aw_got_r <= 1'b1;
                    addr_r   <= s_axi.awaddr;
                    id_r     <= s_axi.awid;
                    len_r    <= s_axi.awlen;
                    size_r   <= s_axi.awsize;
                end
                if (w_hs) begin
                    w_got_r <= 1'b1;
                    wdata_r <= s_axi.wdata;
                    wlast_r <= s_axi.wlast;
                end
                if (state_n != e_idle) begin
                    aw_got_r <= 1'b0;
                    w_got_r  <= 1'b0;
                    err_r    <= (state_n != e_send);
                end
            end
        end
    end

    bsg_parallel_in_serial_out #(
        .width_p (fifo_data_width_p),
        .els_p   (nbf_flits_lp)
    ) piso (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .valid_i     (piso_load),
        .data_i      (pkt_padded_c),
        .ready_and_o (piso_ready),
        .valid_o     (io_v_o),
        .data_o      (io_data_o),
        .last_o      (piso_last),
        .yumi_i      (io_v_o & io_ready_and_i)
    );

    // Read FSM: state register and beat bookkeeping
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rstate_r <= e_ridle;
            rid_r    <= '0;
            rlen_r   <= '0;
            rcnt_r   <= '0;
        end else begin
            rstate_r <= rstate_n;
            if (ar_hs) begin
                rid_r  <= s_axi.arid;
                rlen_r <= s_axi.arlen;
                rcnt_r <= '0;
            end else if (r_hs) begin
                rcnt_r <= rcnt_r + 8'd1;
            end
        end
    end

    // Read FSM: next state
    always_comb begin
        rstate_n = rstate_r;
        unique case (rstate_r)
            e_ridle: if (ar_hs)                     rstate_n = e_rresp;
            e_rresp: if (r_hs && (rcnt_r == rlen_r)) rstate_n = e_ridle;
            default:                                rstate_n = e_ridle;
        endcase
    end

    // Read FSM: outputs; every read beat is an error with zero data
    always_comb begin
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        s_axi.rlast   = 1'b0;
        s_axi.rid     = '0;
        s_axi.rresp   = axi_resp_okay;
        s_axi.rdata   = '0;
        unique case (rstate_r)
            e_ridle: s_axi.arready = rst_done_r;
            e_rresp: begin
                s_axi.rvalid = 1'b1;
                s_axi.rlast  = (rcnt_r == rlen_r);
                s_axi.rid    = rid_r;
                s_axi.rresp  = axi_resp_slverr;
            end
            default: ;
        endcase
    end

    logic unused_axi_fields;
    assign unused_axi_fields = ^{s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot,
                                 s_axi.awqos, s_axi.awregion, s_axi.wstrb, s_axi.araddr,
                                 s_axi.arsize, s_axi.arburst, s_axi.arlock, s_axi.arcache,
                                 s_axi.arprot, s_axi.arqos, s_axi.arregion};

endmodule
